// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the receiver lock-state encoding.
// Shared with the sync generator so that both ends agree on the frame geometry.
package vga_timing_pkg;

    localparam int unsigned VGA_H_ACTIVE   = 640;
    localparam int unsigned VGA_H_FP       = 16;
    localparam int unsigned VGA_H_PULSE    = 96;
    localparam int unsigned VGA_H_BP       = 48;
    localparam int unsigned VGA_V_ACTIVE   = 480;
    localparam int unsigned VGA_V_FP       = 10;
    localparam int unsigned VGA_V_PULSE    = 2;
    localparam int unsigned VGA_V_BP       = 33;
    localparam int unsigned VGA_LOCK_LINES = 8;

    localparam int unsigned VGA_BLACK_H = VGA_H_FP + VGA_H_PULSE + VGA_H_BP;
    localparam int unsigned VGA_H_TOTAL = VGA_BLACK_H + VGA_H_ACTIVE;
    localparam int unsigned VGA_BLACK_V = VGA_V_FP + VGA_V_PULSE + VGA_V_BP;
    localparam int unsigned VGA_V_TOTAL = VGA_BLACK_V + VGA_V_ACTIVE;

    localparam int unsigned CNT_W = 10;
    localparam int unsigned LEN_W = 11;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HLOCK  = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

endpackage

// File: rtl/vga_sync_edge.sv
// Two-flop sampler for an active-low sync input plus leading (falling) edge detect.
// Samplers reset to the idle-high level so reset release never reports an edge.
module vga_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic sync_in,
    output logic fall_c
);

    logic s1_q, s1_d, s2_q, s2_d;

    always_comb begin
        s1_d = sync_in;
        s2_d = s1_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign fall_c = !s1_q && s2_q;

endmodule

// File: rtl/vga_sync_recovery.sv
// VGA sync receiver: recovers pixel coordinates and activevideo from hsync/vsync and tracks lock.
// Build option VGA_RX_FLYWHEEL_EN lets LOCKED ride through up to 3 consecutive bad lines.
module vga_sync_recovery
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = VGA_H_ACTIVE,
    parameter int unsigned H_FP       = VGA_H_FP,
    parameter int unsigned H_PULSE    = VGA_H_PULSE,
    parameter int unsigned H_BP       = VGA_H_BP,
    parameter int unsigned V_ACTIVE   = VGA_V_ACTIVE,
    parameter int unsigned V_FP       = VGA_V_FP,
    parameter int unsigned V_PULSE    = VGA_V_PULSE,
    parameter int unsigned V_BP       = VGA_V_BP,
    parameter int unsigned LOCK_LINES = VGA_LOCK_LINES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hsync_in,
    input  logic             vsync_in,
    output logic [CNT_W-1:0] x_px,
    output logic [CNT_W-1:0] y_px,
    output logic             activevideo,
    output logic             locked,
    output logic             frame_start,
    output logic             sync_err
);

    localparam int unsigned BLACK_H = H_FP + H_PULSE + H_BP;
    localparam int unsigned H_TOTAL = BLACK_H + H_ACTIVE;
    localparam int unsigned BLACK_V = V_FP + V_PULSE + V_BP;
    localparam int unsigned V_TOTAL = BLACK_V + V_ACTIVE;
    localparam int unsigned GOOD_W  = $clog2(LOCK_LINES + 1);

    logic hs_fall_c, vs_fall_c;

    vga_sync_edge u_hs_edge (.clk(clk), .rst(rst), .sync_in(hsync_in), .fall_c(hs_fall_c));
    vga_sync_edge u_vs_edge (.clk(clk), .rst(rst), .sync_in(vsync_in), .fall_c(vs_fall_c));

    logic [CNT_W-1:0]  hc_q, hc_d, vc_q, vc_d, line_q, line_d, x_q, x_d, y_q, y_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [GOOD_W-1:0] good_q, good_d;
    lock_state_e       state_q, state_d;
    logic armed_q, armed_d, locked_q, locked_d, fs_q, fs_d, err_q, err_d;
    logic good_line_c, bad_line_c, good_frame_c, bad_frame_c, hs_align_c, active_c;
    logic [CNT_W-1:0]  line_inc_c;
`ifdef VGA_RX_FLYWHEEL_EN
    logic [1:0] miss_q, miss_d;
`endif

    always_comb begin
        hc_d    = hc_q;
        vc_d    = vc_q;
        len_d   = len_q;
        line_d  = line_q;
        good_d  = good_q;
        state_d = state_q;
        armed_d = armed_q;
        err_d   = 1'b0;
`ifdef VGA_RX_FLYWHEEL_EN
        miss_d  = miss_q;
`endif

        // Line and frame quality; a missing edge is reported once, when len_q first hits H_TOTAL
        good_line_c  = hs_fall_c && (len_q == LEN_W'(H_TOTAL - 1));
        bad_line_c   = hs_fall_c ? (len_q != LEN_W'(H_TOTAL - 1)) : (len_q == LEN_W'(H_TOTAL));
        line_inc_c   = (hs_fall_c && (line_q != '1)) ? line_q + CNT_W'(1) : line_q;
        good_frame_c = vs_fall_c && armed_q && (line_inc_c == CNT_W'(V_TOTAL));
        bad_frame_c  = vs_fall_c && armed_q && (line_inc_c != CNT_W'(V_TOTAL));
        active_c     = (state_q == LOCKED) && (hc_q >= CNT_W'(BLACK_H)) && (vc_q >= CNT_W'(BLACK_V));

        if (hs_fall_c) begin
            len_d = '0;
        end else if (len_q != '1) begin
            len_d = len_q + LEN_W'(1);
        end
        line_d = vs_fall_c ? '0 : line_inc_c;

        case (state_q)
            SEARCH: begin
                if (good_q == GOOD_W'(LOCK_LINES)) begin
                    state_d = HLOCK;
                    good_d  = '0;
                end else if (bad_line_c) begin
                    good_d = '0;
                end else if (good_line_c) begin
                    good_d = good_q + GOOD_W'(1);
                end
            end
            HLOCK: begin
                if (bad_line_c || bad_frame_c) begin
                    state_d = SEARCH;
                end else if (good_frame_c) begin
                    state_d = LOCKED;
                end
            end
            LOCKED: begin
                err_d = bad_line_c || bad_frame_c;
`ifdef VGA_RX_FLYWHEEL_EN
                if (bad_frame_c || (bad_line_c && (miss_q == 2'd3))) begin
                    state_d = SEARCH;
                    miss_d  = '0;
                end else if (bad_line_c) begin
                    miss_d = miss_q + 2'd1;
                end else if (good_line_c) begin
                    miss_d = '0;
                end
`else
                if (bad_line_c || bad_frame_c) begin
                    state_d = SEARCH;
                end
`endif
            end
            default: state_d = SEARCH;
        endcase

        // The first vsync after entering SEARCH or HLOCK only arms frame checking
        if ((state_d != state_q) && (state_d != LOCKED)) begin
            armed_d = 1'b0;
        end else if (vs_fall_c) begin
            armed_d = 1'b1;
        end

`ifdef VGA_RX_FLYWHEEL_EN
        hs_align_c = hs_fall_c && !((state_q == LOCKED) && bad_line_c);
`else
        hs_align_c = hs_fall_c;
`endif

        // Edge seen one cycle after the source's, so realign two past the front porch
        if (hs_align_c) begin
            hc_d = CNT_W'(H_FP + 2);
        end else if (hc_q == CNT_W'(H_TOTAL - 1)) begin
            hc_d = '0;
            vc_d = (vc_q == CNT_W'(V_TOTAL - 1)) ? '0 : vc_q + CNT_W'(1);
        end else begin
            hc_d = hc_q + CNT_W'(1);
        end
        if (vs_fall_c) begin
            vc_d = CNT_W'(V_FP);
        end

        x_d      = active_c ? hc_q - CNT_W'(BLACK_H) : '0;
        y_d      = active_c ? vc_q - CNT_W'(BLACK_V) : '0;
        locked_d = (state_d == LOCKED);
        fs_d     = locked_d && (hc_d == '0) && (vc_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hc_q     <= '0;
            vc_q     <= '0;
            len_q    <= '0;
            line_q   <= '0;
            good_q   <= '0;
            state_q  <= SEARCH;
            armed_q  <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            locked_q <= 1'b0;
            fs_q     <= 1'b0;
            err_q    <= 1'b0;
`ifdef VGA_RX_FLYWHEEL_EN
            miss_q   <= '0;
`endif
        end else begin
            hc_q     <= hc_d;
            vc_q     <= vc_d;
            len_q    <= len_d;
            line_q   <= line_d;
            good_q   <= good_d;
            state_q  <= state_d;
            armed_q  <= armed_d;
            x_q      <= x_d;
            y_q      <= y_d;
            locked_q <= locked_d;
            fs_q     <= fs_d;
            err_q    <= err_d;
`ifdef VGA_RX_FLYWHEEL_EN
            miss_q   <= miss_d;
`endif
        end
    end

    assign x_px        = x_q;
    assign y_px        = y_q;
    assign activevideo = active_c;
    assign locked      = locked_q;
    assign frame_start = fs_q;
    assign sync_err    = err_q;

endmodule
